ascon_output_collector: RTL
===========================

// Module: ascon_output_collector
// PURPOSE
//  Downstream stage of ascon_top. Captures each 128-bit ciphertext block on cipher_valid_i
//  and the tag on end_i, then emits one byte stream (ciphertext then tag) on a valid/ready port.
//  The final ciphertext block is truncated to its real length: padding bytes are never emitted.
//  Decouples the one-cycle cipher pulses of the core from a slower, back-pressured byte consumer.
// PARAMETERS
//  DEPTH          4   ciphertext block FIFO depth in 128-bit words; power of 2, >=2
//  BYTE_LSB_FIRST 1   1: byte 0 of a word is bits [7:0] (ASCON little-endian order); 0: bits [127:120]
// PORTS
//  clock_i         in   1    system clock, rising edge
//  resetb_i        in   1    asynchronous reset, active low
//  start_i         in   1    1-cycle pulse: new message; flushes FIFO and clears flags
//  last_bytes_i    in   5    valid bytes in final ciphertext block (1..16), sampled on start_i
//  cipher_i        in   128  ciphertext block from ascon_top
//  cipher_valid_i  in   1    1-cycle strobe: cipher_i valid
//  tag_i           in   128  tag from ascon_top
//  end_i           in   1    level from ascon_top: computation done, tag_i valid
//  byte_o          out  8    output byte
//  byte_valid_o    out  1    byte_o valid
//  byte_ready_i    in   1    consumer accepts byte_o when byte_valid_o & byte_ready_i
//  byte_last_o     out  1    set with the last tag byte
//  busy_o          out  1    high from start_i until the last tag byte transfers
//  overflow_o      out  1    sticky: a block arrived with FIFO full and was dropped
// BEHAVIOUR
//  Reset (resetb_i=0, asynchronous): state IDLE; FIFO empty; byte counter 0; all outputs 0.
//  FSM: IDLE -start_i-> RUN -(end_seen & FIFO empty & no pending byte)-> TAG -last tag byte xfer-> IDLE.
//   start_i in any state: FIFO flushed, end_seen/overflow_o cleared, last_bytes_i latched; go to RUN.
//   last_bytes_i 0 or >16 is latched as 16.
//  RUN:
//   - cipher_valid_i pushes cipher_i. Push allowed if count<DEPTH or a pop happens in the same cycle.
//     Otherwise the block is dropped and overflow_o is set (sticky).
//   - end_seen is set on the first cycle end_i=1 in RUN; tag_i is captured into the tag register
//     on that same edge. Later changes of tag_i/end_i are ignored until the next start_i.
//   - The head word drains only if count>=2 or end_seen=1, so the final block is identified.
//     Head is final when end_seen=1 and count=1: emit latched last_bytes bytes, else 16.
//   - Byte index counts 0..N-1 within the head word; the head pops on transfer of byte N-1.
//  TAG: emits 16 bytes of the captured tag in the same byte order. byte_last_o=1 only on byte 15.
//  end_i with an empty FIFO (no ciphertext) goes directly to TAG.
//  Output handshake:
//   - byte_o/byte_valid_o/byte_last_o are registered.
//   - Once byte_valid_o=1, outputs stay stable until byte_ready_i=1.
//   - byte_valid_o may rise no earlier than 1 cycle after the data is available.
//   - Sustained throughput is 1 byte/cycle with byte_ready_i held at 1.
//  cipher_valid_i or end_i in IDLE: ignored, no overflow. busy_o=0 only in IDLE.
//  Width rules: FIFO count is $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH; byte index is 4 bits.
// TESTING
//  1 ASCON vector: three blocks then end_i, last_bytes_i=15, key 691AED63..., nonce 46487B3E...
//    ready=1 -> 63 bytes: ciphertext 21,11,d3,...,b9,42 (47 bytes), then tag db,18,43,...,66,f3;
//    byte_last_o on byte 63 only.
//  2 Back-pressure: byte_ready_i random 30% duty on vector 1
//    -> identical byte sequence; byte_o stable while valid & !ready.
//  3 Overflow, DEPTH=4, ready=0: push 5 blocks -> overflow_o=1 after 5th; release ready -> only
//    blocks 1-4 emitted; start_i clears overflow_o.
//  4 Tag only: start_i then end_i, no blocks, tag_i=0x0F0E..00 -> 16 bytes 00,01,...,0F; last on 0F.
//  5 last_bytes_i=16 and =1 with one block 0x00112233..FF
//    -> 16 bytes FF..00, and 1 byte FF, then tag.
//  6 Reset/restart mid-stream: resetb_i low during byte 20 -> outputs 0 asynchronously.
//    start_i mid-RUN -> FIFO flushed; next message emitted alone and correctly.

Source files
------------

// File: rtl/ascon_output_collector.sv
// Collects ASCON ciphertext blocks and the tag, then streams them out as bytes on a
// valid/ready port. The final ciphertext block is cut to its real length.
module ascon_output_collector #(
   parameter int DEPTH          = 4,
   parameter bit BYTE_LSB_FIRST = 1'b1
) (
   input  logic         clock_i,
   input  logic         resetb_i,
   input  logic         start_i,
   input  logic [4:0]   last_bytes_i,
   input  logic [127:0] cipher_i,
   input  logic         cipher_valid_i,
   input  logic [127:0] tag_i,
   input  logic         end_i,
   output logic [7:0]   byte_o,
   output logic         byte_valid_o,
   input  logic         byte_ready_i,
   output logic         byte_last_o,
   output logic         busy_o,
   output logic         overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, TAG} state_t;

   state_t         state_q, state_d;
   logic [127:0]   fifo_mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           end_seen;
   logic [127:0]   tag_reg;
   logic [3:0]     last_idx;
   logic [3:0]     byte_idx;

   logic           out_free, head_ok, head_final;
   logic           load_cipher, load_tag, push, pop, drop, capture_tag, xfer_last;
   logic [3:0]     head_last;
   logic [7:0]     next_byte;

   // Byte count 1..16 to index of the final byte; 0 and >16 mean a full block.
   function automatic logic [3:0] len_to_idx(input logic [4:0] len);
      if (len > 5'd16) return 4'd15;
      return len[3:0] - 4'd1;
   endfunction

   function automatic logic [7:0] pick_byte(input logic [127:0] w, input logic [3:0] idx);
      logic [6:0] base;
      base = BYTE_LSB_FIRST ? {idx, 3'b000} : {~idx, 3'b000};
      return w[base +: 8];
   endfunction

   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      pop         = 1'b0;
      drop        = 1'b0;
      capture_tag = 1'b0;
      load_cipher = 1'b0;
      load_tag    = 1'b0;
      next_byte   = 8'h00;
      out_free    = !byte_valid_o || byte_ready_i;
      xfer_last   = byte_valid_o && byte_ready_i && byte_last_o;
      // The head may only drain once we know whether it is the final (truncated) block.
      head_final  = end_seen && (count == CW'(1));
      head_ok     = (count >= CW'(2)) || head_final;
      head_last   = head_final ? last_idx : 4'd15;
      case (state_q)
         RUN: begin
            load_cipher = head_ok && out_free;
            pop         = load_cipher && (byte_idx == head_last);
            push        = cipher_valid_i && ((count < DEPTH_C) || pop);
            drop        = cipher_valid_i && !push;
            capture_tag = end_i && !end_seen;
            next_byte   = pick_byte(fifo_mem[rd_ptr], byte_idx);
            if (end_seen && (count == '0) && out_free) state_d = TAG;
         end
         TAG: begin
            load_tag  = out_free && !byte_last_o;
            next_byte = pick_byte(tag_reg, byte_idx);
            if (xfer_last) state_d = IDLE;
         end
         default: ;
      endcase
      if (start_i) begin
         state_d     = RUN;
         push        = 1'b0;
         pop         = 1'b0;
         drop        = 1'b0;
         capture_tag = 1'b0;
         load_cipher = 1'b0;
         load_tag    = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         end_seen     <= 1'b0;
         overflow_o   <= 1'b0;
         last_idx     <= 4'd0;
         byte_idx     <= 4'd0;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         byte_last_o  <= 1'b0;
      end else if (start_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         end_seen     <= 1'b0;
         overflow_o   <= 1'b0;
         last_idx     <= len_to_idx(last_bytes_i);
         byte_idx     <= 4'd0;
         byte_valid_o <= 1'b0;
         byte_last_o  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (drop)        overflow_o <= 1'b1;
         if (capture_tag) end_seen   <= 1'b1;
         if (load_cipher || load_tag) begin
            byte_o       <= next_byte;
            byte_valid_o <= 1'b1;
            byte_last_o  <= load_tag && (byte_idx == 4'd15);
            byte_idx     <= pop ? 4'd0 : byte_idx + 4'd1;
         end else if (byte_ready_i) begin
            byte_valid_o <= 1'b0;
            byte_last_o  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (push)        fifo_mem[wr_ptr] <= cipher_i;
      if (capture_tag) tag_reg          <= tag_i;
   end

   assign busy_o = (state_q != IDLE);

endmodule
